rns2bin_mrc: RTL and testbench

//  Reverse converter: takes an RNS value in moduli (8,7,5,3), M = 840, and returns
//  the 10-bit binary value by sequential mixed-radix conversion (MRC).

---
 rtl/rns2bin_mrc.sv | 242 ++++++++++++++++++++++++
 tb/tb_rns2bin_mrc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rns2bin_mrc.sv
// Reverse converter for the RNS base (8,7,5,3), M = 840.
// Sequential mixed-radix conversion: a1..a4 are the mixed-radix digits and
// X = a1 + 8*a2 + 56*a3 + 280*a4. One residue set in flight at a time,
// with a valid/ready handshake on both sides.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a residue set, in_ready_o = 1
// S_1    | a2 = (r7-a1) mod 7, t5 = 2*(r5-a1) mod 5, t3 = 2*(r3-a1) mod 3
// S_2    | a3 = 3*(t5-a2) mod 5, t3 = (t3-a2) mod 3
// S_3    | a4 = 2*(t3-a3) mod 3, assemble X and register the result
// S_OUT  | result presented, held until out_ready_i
//
// The multipliers 2, 3, 2 are the modular inverses of 8 mod 5, 7 mod 5 and
// 5 mod 3; 8 mod 7 and 7 mod 3 are 1, so those steps need no multiply.
// All reductions use compare-and-subtract, so no divider is built.
// Illegal residues run the same arithmetic; the result is discarded and
// replaced by 0 with out_err_o set, keeping the latency data-independent.

module rns2bin_mrc #(
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [2:0] mod8_i,
    input  logic [2:0] mod7_i,
    input  logic [2:0] mod5_i,
    input  logic [1:0] mod3_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [9:0] bin_out_o,
    output logic       out_err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_2    = 3'd2,
        S_3    = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Small modular helpers
    // ------------------------------------------------------------------
    function automatic logic [2:0] red7(input logic [2:0] x);
        return (x == 3'd7) ? 3'd0 : x;
    endfunction

    function automatic logic [2:0] red5(input logic [2:0] x);
        return (x >= 3'd5) ? (x - 3'd5) : x;
    endfunction

    function automatic logic [1:0] red3(input logic [2:0] x);
        logic [2:0] y;
        if (x >= 3'd6)
            y = x - 3'd6;
        else if (x >= 3'd3)
            y = x - 3'd3;
        else
            y = x;
        return y[1:0];
    endfunction

    function automatic logic [2:0] sub7(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] d;
        if (a >= b)
            d = {1'b0, a} - {1'b0, b};
        else
            d = {1'b0, a} + 4'd7 - {1'b0, b};
        return d[2:0];
    endfunction

    function automatic logic [2:0] sub5(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] d;
        if (a >= b)
            d = {1'b0, a} - {1'b0, b};
        else
            d = {1'b0, a} + 4'd5 - {1'b0, b};
        return d[2:0];
    endfunction

    function automatic logic [1:0] sub3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] d;
        if (a >= b)
            d = {1'b0, a} - {1'b0, b};
        else
            d = {1'b0, a} + 3'd3 - {1'b0, b};
        return d[1:0];
    endfunction

    function automatic logic [2:0] mul2_mod5(input logic [2:0] x);
        logic [3:0] y;
        y = {x, 1'b0};
        if (y >= 4'd10)
            y = y - 4'd10;
        else if (y >= 4'd5)
            y = y - 4'd5;
        return y[2:0];
    endfunction

    function automatic logic [2:0] mul3_mod5(input logic [2:0] x);
        logic [4:0] y;
        y = {2'b00, x} + {1'b0, x, 1'b0};
        if (y >= 5'd10)
            y = y - 5'd10;
        else if (y >= 5'd5)
            y = y - 5'd5;
        return y[2:0];
    endfunction

    function automatic logic [1:0] mul2_mod3(input logic [1:0] x);
        logic [2:0] y;
        y = {x, 1'b0};
        if (y >= 3'd3)
            y = y - 3'd3;
        return y[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t     state_q;
    logic       in_ready_q;
    logic [2:0] r7_q;
    logic [2:0] r5_q;
    logic [1:0] r3_q;
    logic [2:0] a1_q;
    logic [2:0] a2_q;
    logic [2:0] a3_q;
    logic [2:0] t5_q;
    logic [1:0] t3_q;
    logic       err_q;
    logic       out_valid_q;
    logic       out_err_q;
    logic [9:0] bin_q;

    // Per-stage arithmetic results
    logic [2:0] s1_a2_d;
    logic [2:0] s1_t5_d;
    logic [1:0] s1_t3_d;
    logic [2:0] s2_a3_d;
    logic [1:0] s2_t3_d;
    logic [1:0] s3_a4_d;
    logic [9:0] x_d;
    logic [9:0] bin_d;
    logic       in_err_d;

    // Mixed-radix digit arithmetic for each stage, evaluated from the registered operands
    always_comb begin
        s1_a2_d = sub7(r7_q, red7(a1_q));
        s1_t5_d = mul2_mod5(sub5(r5_q, red5(a1_q)));
        s1_t3_d = mul2_mod3(sub3(r3_q, red3(a1_q)));
        s2_a3_d = mul3_mod5(sub5(t5_q, red5(a2_q)));
        s2_t3_d = sub3(t3_q, red3(a2_q));
        s3_a4_d = mul2_mod3(sub3(t3_q, red3(a3_q)));
        x_d     = {7'd0, a1_q}
                + {4'd0, a2_q, 3'd0}
                + 10'(a3_q) * 10'd56
                + 10'(s3_a4_d) * 10'd280;
        if (err_q)
            bin_d = 10'd0;
        else if (SIGNED_OUT && (x_d >= 10'd420))
            bin_d = x_d - 10'd840;
        else
            bin_d = x_d;
        in_err_d = (mod7_i == 3'd7) | (mod5_i > 3'd4) | (mod3_i == 2'd3);
    end

    // Conversion FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            r7_q        <= 3'd0;
            r5_q        <= 3'd0;
            r3_q        <= 2'd0;
            a1_q        <= 3'd0;
            a2_q        <= 3'd0;
            a3_q        <= 3'd0;
            t5_q        <= 3'd0;
            t3_q        <= 2'd0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            bin_q       <= 10'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r7_q       <= mod7_i;
                        r5_q       <= mod5_i;
                        r3_q       <= mod3_i;
                        a1_q       <= mod8_i;
                        err_q      <= in_err_d;
                        in_ready_q <= 1'b0;
                        state_q    <= S_1;
                    end
                end
                S_1: begin
                    a2_q    <= s1_a2_d;
                    t5_q    <= s1_t5_d;
                    t3_q    <= s1_t3_d;
                    state_q <= S_2;
                end
                S_2: begin
                    a3_q    <= s2_a3_d;
                    t3_q    <= s2_t3_d;
                    state_q <= S_3;
                end
                S_3: begin
                    bin_q       <= bin_d;
                    out_err_q   <= err_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    out_err_q   <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_err_o   = out_err_q;
    assign bin_out_o   = bin_q;

endmodule

// File: tb/tb_rns2bin_mrc.sv
// Scoreboard bench for rns2bin_mrc: a signed and an unsigned instance share
// the stimulus; expected results are queued at issue and checked on output.

module tb_rns2bin_mrc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [2:0] m8 = 3'd0;
    logic [2:0] m7 = 3'd0;
    logic [2:0] m5 = 3'd0;
    logic [1:0] m3 = 2'd0;
    logic       rdy_s, rdy_u, vld_s, vld_u, err_s, err_u;
    logic [9:0] bin_s, bin_u;

    always #5 clk = ~clk;

    rns2bin_mrc #(.SIGNED_OUT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_s),
        .mod8_i(m8), .mod7_i(m7), .mod5_i(m5), .mod3_i(m3),
        .out_valid_o(vld_s), .out_ready_i(out_ready), .bin_out_o(bin_s), .out_err_o(err_s)
    );

    rns2bin_mrc #(.SIGNED_OUT(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_u),
        .mod8_i(m8), .mod7_i(m7), .mod5_i(m5), .mod3_i(m3),
        .out_valid_o(vld_u), .out_ready_i(out_ready), .bin_out_o(bin_u), .out_err_o(err_u)
    );

    typedef struct {
        logic [9:0] bs;
        logic [9:0] bu;
        logic       err;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: latency on each rising out_valid, values on each handshake
    always @(negedge clk) begin
        if (vld_s && !prev_v) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got bin=%0d with no conversion pending (t=%0t)", bin_s, $time);
            end else begin
                chk("latency", 16'(cyc - sbq[0].acc), 16'd3);
            end
        end
        if (vld_s && out_ready && sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("bin_signed", {6'd0, bin_s}, {6'd0, mon_e.bs});
            chk("err_signed", {15'd0, err_s}, {15'd0, mon_e.err});
            chk("bin_unsigned", {6'd0, bin_u}, {6'd0, mon_e.bu});
            chk("err_unsigned", {15'd0, err_u}, {15'd0, mon_e.err});
            chk("valid_unsigned", {15'd0, vld_u}, 16'd1);
        end
        prev_v = vld_s;
    end

    // Issue one residue set; call and return at posedge+2
    task automatic send(input logic [2:0] a8, input logic [2:0] a7, input logic [2:0] a5,
                        input logic [1:0] a3, input logic [9:0] es, input logic [9:0] eu,
                        input logic ee, input bit push);
        int   n;
        exp_t e;
        n = 0;
        while (!(rdy_s && rdy_u) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!(rdy_s && rdy_u)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1 within 100 cycles");
            return;
        end
        m8 = a8;
        m7 = a7;
        m5 = a5;
        m3 = a3;
        in_valid = 1'b1;
        if (push) begin
            e.bs  = es;
            e.bu  = eu;
            e.err = ee;
            e.acc = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int xs;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", {15'd0, rdy_s}, 16'd1);
        chk("rst_out_valid", {15'd0, vld_s}, 16'd0);
        chk("rst_bin", {6'd0, bin_s}, 16'd0);
        chk("rst_err", {15'd0, err_s}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Directed vectors (mod8, mod7, mod5, mod3) -> signed, unsigned, err
        send(3'd4, 3'd2, 3'd0, 2'd1, 10'd100, 10'd100, 1'b0, 1'b1);
        send(3'd7, 3'd6, 3'd4, 2'd2, 10'h3FF, 10'd839, 1'b0, 1'b1);
        send(3'd3, 3'd6, 3'd4, 2'd2, 10'd419, 10'd419, 1'b0, 1'b1);
        send(3'd4, 3'd0, 3'd0, 2'd0, 10'h25C, 10'd420, 1'b0, 1'b1);
        send(3'd0, 3'd0, 3'd0, 2'd0, 10'd0, 10'd0, 1'b0, 1'b1);
        send(3'd0, 3'd0, 3'd6, 2'd0, 10'd0, 10'd0, 1'b1, 1'b1);
        send(3'd1, 3'd7, 3'd1, 2'd1, 10'd0, 10'd0, 1'b1, 1'b1);
        send(3'd1, 3'd1, 3'd1, 2'd3, 10'd0, 10'd0, 1'b1, 1'b1);
        send(3'd5, 3'd5, 3'd0, 2'd2, 10'd5, 10'd5, 1'b0, 1'b1);
        drain();

        // Downstream stall: result held, new input ignored
        out_ready = 1'b0;
        send(3'd3, 3'd6, 3'd4, 2'd2, 10'd419, 10'd419, 1'b0, 1'b1);
        n = 0;
        while (!vld_s && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            m8 = 3'd4;
            m7 = 3'd2;
            m5 = 3'd0;
            m3 = 2'd1;
            in_valid = 1'b1;
            chk("stall_valid", {15'd0, vld_s}, 16'd1);
            chk("stall_in_ready", {15'd0, rdy_s}, 16'd0);
            chk("stall_bin", {6'd0, bin_s}, 16'd419);
            chk("stall_err", {15'd0, err_s}, 16'd0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("post_hs_valid", {15'd0, vld_s}, 16'd0);
        chk("post_hs_bin_kept", {6'd0, bin_s}, 16'd419);
        chk("post_hs_in_ready", {15'd0, rdy_s}, 16'd1);
        drain();

        // Reset asserted while the conversion sits in S2
        send(3'd4, 3'd2, 3'd0, 2'd1, 10'd100, 10'd100, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {15'd0, rdy_s}, 16'd1);
        chk("abort_valid", {15'd0, vld_s}, 16'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        chk("after_abort_in_ready", {15'd0, rdy_s}, 16'd1);
        chk("after_abort_valid", {15'd0, vld_s}, 16'd0);
        send(3'd4, 3'd2, 3'd0, 2'd1, 10'd100, 10'd100, 1'b0, 1'b1);
        drain();

        // Round trip of every x through a forward conversion
        for (int x = 0; x < 840; x++) begin
            xs = (x >= 420) ? (x - 840 + 1024) : x;
            send(3'(x % 8), 3'(x % 7), 3'(x % 5), 2'(x % 3), 10'(xs), 10'(x), 1'b0, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
